adder_scheduler: RTL and testbench
==================================

Name: adder_scheduler

Overview:
Round-robin scheduler that shares one 16-bit two's-complement saturating fixed-point adder among NUM_REQ requesters, such as FFT butterfly and magnitude stages. It accepts one request at a time and drives the adder's enable and operands. It waits for the adder's done pulse, then returns the sum tagged with the requester id. Only one operation is in flight at any time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester id; must satisfy 2**ID_W >= NUM_REQ
TIMEOUT_CYCLES, 8, WAIT-state cycle limit (used only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
req_valid  input  NUM_REQ  per-requester request; held with operands until its req_ready pulse
req_a  input  16*NUM_REQ  operand A, requester i in bits [16*i+15:16*i]
req_b  input  16*NUM_REQ  operand B, same packing
req_ready  output  NUM_REQ  one-cycle grant/accept pulse, one-hot
rsp_valid  output  1  one-cycle result pulse
rsp_id  output  ID_W  requester id of the result
rsp_sum  output  16  saturated sum
rsp_err  output  1  timeout flag, qualified by rsp_valid
add_enable  output  1  one-cycle start pulse to the shared adder
add_a  output  16  adder operand A
add_b  output  16  adder operand B
add_sum  input  16  adder result
add_done  input  1  adder completion pulse; arrives 2 cycles after add_enable
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_err=0, add_enable=0, add_a=0, add_b=0, busy=0, state=IDLE, rr pointer=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid is set, grant the first set bit searching from the rr pointer upward with wrap. Latch the grant index, req_a slice and req_b slice into add_a/add_b. Go to ISSUE. If no request is set, stay in IDLE.
- ISSUE (one cycle): req_ready[grant]=1, add_enable=1, busy=1. Go to WAIT.
- WAIT: when add_done=1, capture add_sum into rsp_sum and set rsp_id=grant. Go to RESP.
- RESP (one cycle): rsp_valid=1, rsp_err=0. Set rr pointer = grant+1, wrapping at NUM_REQ. Go to IDLE.
- Latency:
  - req_valid seen in IDLE at cycle 0.
  - req_ready/add_enable high at cycle 1.
  - add_done at cycle 3.
  - rsp_valid at cycle 4.
  - Next grant no earlier than cycle 5, so one op per 5 cycles sustained.
- Fairness: the most recently served requester has lowest priority. With all NUM_REQ requesting continuously, each is served once per NUM_REQ operations.
- req_valid deasserted before its grant: the request is simply not considered. No error.
- Operands are sampled only in IDLE. Changes to req_a/req_b afterwards do not affect the in-flight op.
- add_done while not in WAIT: ignored.
- add_sum is passed through unmodified. Saturation to 0x7FFF/0x8000 is the adder's responsibility.
- Reset mid-operation: return to reset values on the next edge and discard any in-flight result. A late add_done then arrives in IDLE and is ignored.
- Requester ids >= NUM_REQ are never granted.

Optional Feature:
ADDER_TIMEOUT_EN:
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle without add_done. On reaching TIMEOUT_CYCLES, go to RESP with rsp_sum=0 and rsp_err=1. The rr pointer advances as normal.
- Not defined: no counter, WAIT lasts until add_done, and rsp_err is constant 0.

Test Plan:
- Single op: req_valid=4'b0001, A=0x0100, B=0x0200, ideal 2-cycle adder model -> req_ready[0] at cycle 1, add_enable at cycle 1, rsp_valid at cycle 4 with rsp_id=0, rsp_sum=0x0300, rsp_err=0.
- Saturation passthrough: requester 2, A=0x7000, B=0x2000 -> rsp_id=2, rsp_sum=0x7FFF. A=0x8000, B=0xFFFF -> rsp_sum=0x8000.
- Round-robin: req_valid=4'b1111 held, distinct operands -> rsp_id sequence 0,1,2,3,0. req_ready never has more than one bit set. Consecutive rsp_valid pulses are exactly 5 cycles apart.
- Fairness after partial: serve requester 1, then req_valid=4'b0011 -> next grant is 0, then 1.
- Reset mid-WAIT: assert reset the cycle after add_enable; adder model still pulses add_done -> no rsp_valid, all outputs 0, next request granted starting from id 0.
- ADDER_TIMEOUT_EN: adder model never asserts add_done, TIMEOUT_CYCLES=8 -> rsp_valid with rsp_err=1, rsp_sum=0x0000 after 8 WAIT cycles (cycle 11), then a new grant proceeds normally.

Source files
------------

// File: rtl/adder_scheduler.sv
// Round-robin arbiter sharing one 16-bit saturating adder among NUM_REQ requesters, one op in flight.
// Optional build macro ADDER_TIMEOUT_EN: bounds the wait for add_done and flags an expired wait in rsp_err.
`timescale 1ns/1ps

module adder_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_sum,
    output logic                  rsp_err,
    output logic                  add_enable,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    input  logic [15:0]           add_sum,
    input  logic                  add_done,
    output logic                  busy
);

    localparam int unsigned DW = 16;

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("adder_scheduler: invalid parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic            pick_found_c;
    logic [ID_W-1:0] pick_idx_c;
    logic [ID_W-1:0] rr_next_c;

`ifdef ADDER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    logic          err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // First requesting index at or above the rr pointer, wrapping inside NUM_REQ.
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!pick_found_c && req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign rr_next_c = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            req_ready  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            add_enable <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            busy       <= 1'b0;
`ifdef ADDER_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            req_ready  <= '0;
            add_enable <= 1'b0;
            rsp_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found_c) begin
                        grant      <= pick_idx_c;
                        add_a      <= req_a[int'(pick_idx_c) * DW +: DW];
                        add_b      <= req_b[int'(pick_idx_c) * DW +: DW];
                        req_ready  <= NUM_REQ'(1) << pick_idx_c;
                        add_enable <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef ADDER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (add_done) begin
                        rsp_sum   <= add_sum;
                        rsp_id    <= grant;
                        rsp_valid <= 1'b1;
`ifdef ADDER_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef ADDER_TIMEOUT_EN
                    // Adder never answered: report an error result instead of hanging.
                    else if (wait_cnt == TW'(TIMEOUT_CYCLES)) begin
                        rsp_sum   <= '0;
                        rsp_id    <= grant;
                        rsp_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end
                RESP: begin
                    rr_ptr <= rr_next_c;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_scheduler.sv
// Bench for adder_scheduler: vector table plus hand-written reset, stray-done and timeout sequences.
`timescale 1ns/1ps

module tb_adder_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_err;
    logic        add_enable;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        add_done;
    logic        busy;

    adder_scheduler #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_err    (rsp_err),
        .add_enable (add_enable),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .add_done   (add_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal saturating adder, done two cycles after enable.
    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] s;
        s = $signed({a[15], a}) + $signed({b[15], b});
        if (s > 17'sd32767)       return 16'h7FFF;
        else if (s < -17'sd32768) return 16'h8000;
        else                      return s[15:0];
    endfunction

    logic        model_on   = 1'b1;
    logic        stray_done = 1'b0;
    logic        d1 = 1'b0, d2 = 1'b0;
    logic [15:0] s1 = '0, s2 = '0;
    always @(posedge clk) begin
        d1 <= add_enable & model_on;
        s1 <= sat16(add_a, add_b);
        d2 <= d1;
        s2 <= s1;
    end
    assign add_done = d2 | stray_done;
    assign add_sum  = s2;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  id;
        logic [15:0] sum;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int last_rsp_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            chk("no_rsp", 32'(rsp_valid), 32'd0);
        end
    endtask

    // Drive one request, follow it through grant and response, compare against the scoreboard.
    task automatic run_op(input logic [3:0] valid, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] id, input logic [15:0] sum, input logic err,
                          input int lat, input int issue_lat, input int gap);
        int   n;
        int   drive_cyc;
        int   ready_cyc;
        exp_t e;
        req_valid = valid;
        for (int k = 0; k < 4; k++) begin
            req_a[k*16 +: 16] = (k == int'(id)) ? a : a ^ 16'h0F0F;
            req_b[k*16 +: 16] = (k == int'(id)) ? b : b ^ 16'h3030;
        end
        exp_q.push_back('{id: id, sum: sum, err: err});
        drive_cyc = cyc;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (req_ready == 4'd0 && n < 12);
        ready_cyc = cyc;
        chk("req_ready", 32'(req_ready), 32'(4'd1 << id));
        chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
        chk("add_enable", 32'(add_enable), 32'd1);
        chk("busy", 32'(busy), 32'd1);
        if (issue_lat >= 0) chk("issue_latency", 32'(ready_cyc - drive_cyc), 32'(issue_lat));
        // Request withdrawn and operands scrambled: the in-flight op must be unaffected.
        req_valid = 4'd0;
        req_a     = {4{16'hDEAD}};
        req_b     = {4{16'hBEEF}};
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!rsp_valid && n < 20);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_latency", 32'(cyc - ready_cyc), 32'(lat));
        if (gap >= 0) chk("rsp_gap", 32'(cyc - last_rsp_cyc), 32'(gap));
        last_rsp_cyc = cyc;
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
    endtask

    vec_t vecs[12];

    initial begin
        int n;
        vecs[0]  = '{4'b0001, 16'h0100, 16'h0200, 2'd0, 16'h0300};
        vecs[1]  = '{4'b0100, 16'h7000, 16'h2000, 2'd2, 16'h7FFF};
        vecs[2]  = '{4'b0100, 16'h8000, 16'hFFFF, 2'd2, 16'h8000};
        vecs[3]  = '{4'b1111, 16'h0011, 16'h0001, 2'd3, 16'h0012};
        vecs[4]  = '{4'b1111, 16'h0022, 16'h0002, 2'd0, 16'h0024};
        vecs[5]  = '{4'b1111, 16'h0033, 16'h0003, 2'd1, 16'h0036};
        vecs[6]  = '{4'b1111, 16'h0044, 16'h0004, 2'd2, 16'h0048};
        vecs[7]  = '{4'b1111, 16'h0055, 16'h0005, 2'd3, 16'h005A};
        vecs[8]  = '{4'b1111, 16'hFFFF, 16'h0001, 2'd0, 16'h0000};
        vecs[9]  = '{4'b0010, 16'h1000, 16'h1000, 2'd1, 16'h2000};
        vecs[10] = '{4'b0011, 16'h8001, 16'h8001, 2'd0, 16'h8000};
        vecs[11] = '{4'b0011, 16'h0001, 16'h7FFF, 2'd1, 16'h7FFF};

        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_add_enable", 32'(add_enable), 32'd0);
        chk("rst_add_ab", 32'({add_a, add_b}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        idle_cycles(2);

        // Back-to-back ops: each new request is driven in the cycle its predecessor responds.
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].id, vecs[i].sum, 1'b0,
                   3, (i == 0) ? 1 : -1, (i == 0) ? -1 : 5);

        // Reset one cycle after add_enable; the late add_done must be ignored.
        req_valid = 4'b0100; req_a = {4{16'h0001}}; req_b = {4{16'h0001}};
        n = 0;
        do begin @(posedge clk); #1; n++; end while (req_ready == 4'd0 && n < 12);
        chk("mid_req_ready", 32'(req_ready), 32'b0100);
        req_valid = 4'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_add_done_seen", 32'(add_done), 32'd1);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("mid_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_add_ab", 32'({add_a, add_b}), 32'd0);
        chk("mid_req_ready0", 32'({req_ready, add_enable, rsp_err}), 32'd0);
        idle_cycles(5);
        run_op(4'b1111, 16'h0123, 16'h0456, 2'd0, 16'h0579, 1'b0, 3, 1, -1);

        // Stray add_done while idle.
        @(posedge clk); #1;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        idle_cycles(4);
        chk("stray_busy", 32'(busy), 32'd0);
        run_op(4'b1000, 16'h4000, 16'h4000, 2'd3, 16'h7FFF, 1'b0, 3, 1, -1);

`ifdef ADDER_TIMEOUT_EN
        model_on = 1'b0;
        run_op(4'b0001, 16'h0007, 16'h0008, 2'd0, 16'h0000, 1'b1, 10, -1, -1);
        model_on = 1'b1;
        run_op(4'b0010, 16'h0005, 16'h0006, 2'd1, 16'h000B, 1'b0, 3, -1, 5);
`endif

        idle_cycles(3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
